// File: rtl/rv32_types.sv
// Shared RV32 front-end types: instruction word, fetch buffer payload and fetch FSM states.
package rv32_types;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] rv32_word;

  // addi x0, x0, 0
  localparam rv32_word RV_NOP = 32'h0000_0013;

  typedef struct packed {
    rv32_word pc;
    rv32_word instr;
  } fetch_buffer_data_t;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Fall-through response buffer plus in-order pc queue of outstanding fetch requests.
// An incoming response is visible at the head in the same cycle when the buffer is empty.
module rv32_fetch_fifo
  import rv32_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       pc_push,
  input  rv32_word                   pc_push_addr,
  input  logic                       rsp_push,
  input  rv32_word                   rsp_instr,
  input  logic                       pop,
  output logic                       head_valid_c,
  output fetch_buffer_data_t         head_c,
  output logic                       pc_valid_c,
  output rv32_word                   pc_head_c,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_buffer_data_t data_mem [DEPTH];
  rv32_word           pc_mem   [DEPTH];
  logic [IW-1:0]      wr_ptr, rd_ptr, pc_wr_ptr, pc_rd_ptr;
  logic [CW-1:0]      pc_count;
  logic               stored_valid, store, take, pc_take;
  fetch_buffer_data_t rsp_entry;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  // Head selection and push/pop qualification; a pop on an empty buffer consumes the bypassed response.
  always_comb begin
    stored_valid = (count != '0);
    pc_valid_c   = (pc_count != '0);
    pc_head_c    = pc_mem[pc_rd_ptr];
    rsp_entry    = '{pc: pc_head_c, instr: rsp_instr};
    head_valid_c = stored_valid || rsp_push;
    if (stored_valid) begin
      head_c = data_mem[rd_ptr];
    end else begin
      head_c = rsp_entry;
    end
    take    = pop && stored_valid;
    store   = rsp_push && !(pop && !stored_valid);
    pc_take = rsp_push && pc_valid_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pc_wr_ptr <= '0;
      pc_rd_ptr <= '0;
      pc_count  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pc_wr_ptr <= '0;
      pc_rd_ptr <= '0;
      pc_count  <= '0;
    end else begin
      if (store)   wr_ptr    <= next_ptr(wr_ptr);
      if (take)    rd_ptr    <= next_ptr(rd_ptr);
      if (pc_push) pc_wr_ptr <= next_ptr(pc_wr_ptr);
      if (pc_take) pc_rd_ptr <= next_ptr(pc_rd_ptr);
      count    <= count + CW'(store) - CW'(take);
      pc_count <= pc_count + CW'(pc_push) - CW'(pc_take);
    end
  end

  // Storage arrays carry no reset; validity comes from the counters.
  always_ff @(posedge clk) begin
    if (store && !flush)   data_mem[wr_ptr]  <= rsp_entry;
    if (pc_push && !flush) pc_mem[pc_wr_ptr] <= pc_push_addr;
  end

  // Credit accounting upstream must keep the buffer from ever overflowing.
  assert property (@(posedge clk) disable iff (!resetn)
                   !(store && !take && !flush && count == CW'(DEPTH)))
    else $error("rv32_fetch_fifo: response pushed into a full buffer");

endmodule

// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch stage: credit-limited request issue, in-order response buffering,
// jump redirect with stale-response flushing, registered {pc, instr} to decode.
module rv32_fetch_stage
  import rv32_types::*;
#(
  parameter rv32_word    RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               stall,
  input  logic               jump,
  input  rv32_word           jump_addr,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output rv32_word           imem_addr,
  input  logic               imem_rsp_valid,
  input  rv32_word           imem_rsp_data,
  output fetch_buffer_data_t instr_data
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t       state, state_next;
  rv32_word           fetch_pc, fetch_pc_next, jump_pc, pc_head, nop_pc;
  logic [CW-1:0]      outstanding, outstanding_next, drop_count, drop_count_next, fifo_count;
  fetch_buffer_data_t instr_next, fifo_head;
  logic               fifo_head_valid, pc_valid, credit;
  logic               req_fire, rsp_push, fifo_pop, fifo_flush;

  rv32_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (fifo_flush),
    .pc_push      (req_fire),
    .pc_push_addr (fetch_pc),
    .rsp_push     (rsp_push),
    .rsp_instr    (imem_rsp_data),
    .pop          (fifo_pop),
    .head_valid_c (fifo_head_valid),
    .head_c       (fifo_head),
    .pc_valid_c   (pc_valid),
    .pc_head_c    (pc_head),
    .count        (fifo_count)
  );

  assign imem_addr = fetch_pc;

  // Next-state, counters and decode-side register update.
  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    outstanding_next = outstanding;
    drop_count_next  = drop_count;
    instr_next       = instr_data;
    imem_req_valid   = 1'b0;
    req_fire         = 1'b0;
    rsp_push         = 1'b0;
    fifo_pop         = 1'b0;
    fifo_flush       = 1'b0;
    jump_pc          = jump_addr & ~rv32_word'(32'h3);
    credit           = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    nop_pc           = pc_valid ? pc_head : fetch_pc;

    case (state)
      S_WAIT: state_next = S_FETCH;
      S_FETCH: begin
        imem_req_valid   = credit && !jump;
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_push         = imem_rsp_valid && !jump;
        outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) fetch_pc_next = fetch_pc + 32'd4;
        // Requests still in flight after this edge become responses to throw away.
        if (jump) begin
          drop_count_next  = outstanding_next;
          outstanding_next = '0;
          if (drop_count_next != '0) state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (imem_rsp_valid) drop_count_next = drop_count - CW'(1);
        if (drop_count_next == '0) state_next = S_FETCH;
      end
      default: state_next = S_WAIT;
    endcase

    if (jump) begin
      fetch_pc_next = jump_pc;
      fifo_flush    = 1'b1;
      instr_next    = '{pc: jump_pc, instr: RV_NOP};
    end else if (!stall) begin
      fifo_pop = 1'b1;
      if (fifo_head_valid) begin
        instr_next = fifo_head;
      end else begin
        instr_next = '{pc: nop_pc, instr: RV_NOP};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_WAIT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      instr_data  <= '{pc: RESET_PC, instr: RV_NOP};
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_count  <= drop_count_next;
      instr_data  <= instr_next;
    end
  end

endmodule
